// File: rtl/mini_src_pkg.sv
// Shared DataPath constants: ALU opcodes, data width and divider state encoding.
package mini_src_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SHR = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00101;
    localparam logic [4:0] OP_DIV = 5'b00110;
    localparam logic [4:0] OP_NEG = 5'b00111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ITER  = ST_ITER,
        FIXUP = ST_FIXUP,
        DONE  = ST_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into r, then
// conditionally subtract the divisor and record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_wide;
    logic [WIDTH:0] diff;

    // r can exceed WIDTH bits for one instant after the shift
    assign r_wide = {r, q[WIDTH-1]};
    assign diff   = r_wide - {1'b0, b};

    always_comb begin
        r_next = r_wide[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], 1'b0};
        if (r_wide >= {1'b0, b}) begin
            r_next    = diff[WIDTH-1:0];
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider producing Z = {remainder, quotient}.
module seq_divider
    import mini_src_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               w_clock,
    input  logic               w_clear,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t state, state_next;

    logic [WIDTH-1:0] r_q, q_q, b_q;
    logic [WIDTH-1:0] r_next, q_next;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CNT_W-1:0] cnt;
    logic             a_neg, b_neg;
    logic             sign_q, sign_r;
    logic             pend;

    assign a_neg = i_signed & i_dividend[WIDTH-1];
    assign b_neg = i_signed & i_divisor[WIDTH-1];
    assign a_mag = a_neg ? -i_dividend : i_dividend;
    assign b_mag = b_neg ? -i_divisor : i_divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .b      (b_q),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge w_clock) begin
        if (w_clear) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (i_start)
                       state_next = (i_divisor == '0) ? DONE : ITER;
            ITER:  if (cnt == '0) state_next = FIXUP;
            FIXUP: state_next = DONE;
            DONE:  if (!pend) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state == ITER) || (state == FIXUP);
    // Divide-by-zero holds DONE one extra silent cycle before pulsing
    assign o_done = (state == DONE) && !pend;
    assign o_z    = {o_remainder, o_quotient};

    always_ff @(posedge w_clock) begin
        if (w_clear) begin
            r_q         <= '0;
            q_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            pend        <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_divisor == '0) begin
                            o_quotient  <= '1;
                            o_remainder <= i_dividend;
                            o_div_zero  <= 1'b1;
                            pend        <= 1'b1;
                        end else begin
                            q_q    <= a_mag;
                            b_q    <= b_mag;
                            r_q    <= '0;
                            cnt    <= CNT_W'(WIDTH - 1);
                            sign_q <= a_neg ^ b_neg;
                            sign_r <= a_neg;
                        end
                    end
                end
                ITER: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt - 1'b1;
                end
                FIXUP: begin
                    o_quotient  <= sign_q ? -q_q : q_q;
                    o_remainder <= sign_r ? -r_q : r_q;
                    o_div_zero  <= 1'b0;
                end
                DONE: pend <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, busy and corner sequences.
module tb_seq_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clear;
    logic           start;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [2*W-1:0] z;
    logic           dz;

    int errors = 0;
    int checks = 0;

    seq_divider dut (
        .w_clock     (clk),
        .w_clear     (clear),
        .i_start     (start),
        .i_signed    (sgn),
        .i_dividend  (a),
        .i_divisor   (b),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quo),
        .o_remainder (rem),
        .o_z         (z),
        .o_div_zero  (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic       dz;
        int         edges;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start pulse that is sampled at the next rising edge
    task automatic start_div(input logic s, input logic [W-1:0] x,
                             input logic [W-1:0] y);
        @(negedge clk);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  edges;
        bit  got;
        bit  busy_seen;
        start_div(v.sgn, v.a, v.b);
        edges     = 1;
        got       = 0;
        busy_seen = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        check({v.name, " done_seen"}, 64'(got), 64'd1);
        check({v.name, " edges"}, 64'(edges), 64'(v.edges));
        check({v.name, " q"}, 64'(quo), 64'(v.q));
        check({v.name, " r"}, 64'(rem), 64'(v.r));
        check({v.name, " z"}, z, {v.r, v.q});
        check({v.name, " div_zero"}, 64'(dz), 64'(v.dz));
        check({v.name, " busy_seen"}, 64'(busy_seen), 64'(!v.dz));
        @(negedge clk);
        check({v.name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"u21_7", 1'b0, 32'd21, 32'd7, 32'd3, 32'd0, 1'b0, W + 2};
        vecs[1] = '{"s-21_4", 1'b1, 32'hFFFF_FFEB, 32'd4,
                    32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, W + 2};
        vecs[2] = '{"u7_0", 1'b0, 32'd7, 32'd0,
                    32'hFFFF_FFFF, 32'd7, 1'b1, 2};
        vecs[3] = '{"smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h8000_0000, 32'd0, 1'b0, W + 2};
        vecs[4] = '{"s21_-4", 1'b1, 32'd21, 32'hFFFF_FFFC,
                    32'hFFFF_FFFB, 32'd1, 1'b0, W + 2};
        vecs[5] = '{"s-21_-4", 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFC,
                    32'd5, 32'hFFFF_FFFF, 1'b0, W + 2};
        vecs[6] = '{"u5_7", 1'b0, 32'd5, 32'd7, 32'd0, 32'd5, 1'b0, W + 2};
        vecs[7] = '{"smin_0", 1'b1, 32'h8000_0000, 32'd0,
                    32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 2};
        vecs[8] = '{"u_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000,
                    32'd1, 32'h7FFF_FFFF, 1'b0, W + 2};
        vecs[9] = '{"s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W + 2};

        clear = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset z", z, 64'd0);
        check("reset div_zero", 64'(dz), 64'd0);
        clear = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Re-pulsed start during ITER must be ignored
        begin
            int pulses;
            start_div(1'b0, 32'hFFFF_FFFF, 32'd2);
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("repulse busy", 64'(busy), 64'd1);
            a     = 32'd9;
            b     = 32'd3;
            start = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            pulses = 0;
            for (int i = 0; i < 45; i++) begin
                @(negedge clk);
                if (done) pulses++;
            end
            check("repulse pulses", 64'(pulses), 64'd1);
            check("repulse q", 64'(quo), 64'h7FFF_FFFF);
            check("repulse r", 64'(rem), 64'd1);
            check("repulse idle busy", 64'(busy), 64'd0);
        end

        // Clear in the middle of ITER aborts with no done
        begin
            int pulses;
            start_div(1'b0, 32'd1000, 32'd3);
            repeat (10) @(posedge clk);
            @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            check("clear busy", 64'(busy), 64'd0);
            check("clear done", 64'(done), 64'd0);
            check("clear z", z, 64'd0);
            check("clear div_zero", 64'(dz), 64'd0);
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) pulses++;
            end
            check("clear no_done", 64'(pulses), 64'd0);
            run_vec('{"u100_9", 1'b0, 32'd100, 32'd9,
                      32'd11, 32'd1, 1'b0, W + 2});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
